cu_read_cmd_generator: RTL and testbench
========================================

Name: cu_read_cmd_generator

Overview:
- Converts one read job (byte base address plus element count) into a stream of cacheline-bounded read commands toward AFU-Control's read command buffer.
- Gates issue on a local read-credit pool sized by CREDITS_READ. Credits return one per completed response.
- Signals job completion only after every issued command has been answered.
- Sits between the CU-Control job dispatch (upstream) and the AFU-Control read command buffer and arbiter (downstream).

Parameters:
- NUM_CREDITS, default CREDITS_READ (32): maximum outstanding read commands.
- ELEM_BYTES, default DATA_SIZE_READ (4): bytes per element.
- LINE_BYTES, default CACHELINE_SIZE (128): maximum command size and alignment unit.
- CU_ID, default DATA_READ_CONTROL_ID: ID stamped on every command.

Ports:
- clock  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  high only in IDLE.
- job_base_addr  in  64 ([0:63])  byte address; any alignment allowed.
- job_elem_count  in  32  number of elements.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  downstream accepts.
- cmd_addr  out  64  command byte address.
- cmd_size  out  8  bytes in this command, range 1..LINE_BYTES.
- cmd_cu_id  out  8 (cu_id_t)  constant CU_ID.
- credit_return  in  1  one-cycle pulse per completed response.
- job_done  out  1  one-cycle pulse at completion.
- outstanding  out  6  NUM_CREDITS minus available credits.
- credit_error  out  1  sticky flag, cleared only by rst.

Behaviour:
- Reset values: state IDLE; credits = NUM_CREDITS; all outputs 0 except job_ready = 1. Reset mid-job abandons the job immediately with no job_done pulse.
- Job latch: the job handshake (job_valid && job_ready) latches addr = job_base_addr and remaining = job_elem_count × ELEM_BYTES (38-bit, no overflow), then moves to ISSUE.
- Command sizing: cmd_size = min(LINE_BYTES − (addr & ADDRESS_DATA_READ_MOD_MASK), remaining).
  - Only the first command can be unaligned; every later command is line-aligned.
  - No command crosses a 128 B line, and therefore never crosses a page.
- ISSUE: cmd_valid = (remaining ≠ 0) && (credits ≠ 0).
  - cmd_addr and cmd_size are registered and hold stable while cmd_valid && !cmd_ready.
  - On accept: addr += cmd_size; remaining −= cmd_size; credits −= 1.
  - Back-to-back accepts give 1 command per cycle.
  - When remaining reaches 0 → DRAIN.
- DRAIN: when credits == NUM_CREDITS → DONE.
- DONE: job_done = 1 for exactly one cycle → IDLE. job_ready rises on the cycle after the job_done pulse.
- Zero-length job (count 0): IDLE → DONE directly. job_done pulses 2 cycles after the handshake; no commands are issued.
- Credit accounting:
  - An accept and a credit_return in the same cycle leave credits unchanged.
  - A credit_return with credits == NUM_CREDITS and no accept in that cycle is ignored; it sets credit_error.
  - credits == 0 deasserts cmd_valid on the next cycle. A return in that state re-enables issue the following cycle.
- outstanding is combinational from the credit register.
- credit_return is legal in any state, including IDLE, to drain a prior job.

Optional Feature:
- Macro: CU_READ_CMD_STATS_EN.
- Defined: adds two 32-bit output counters, both cleared on job handshake, saturating, and held after job_done.
  - stall_credit_cycles: counts cycles in ISSUE with remaining ≠ 0 and credits == 0.
  - stall_ready_cycles: counts cycles with cmd_valid && !cmd_ready.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Into GLOBALS_AFU_PKG:
  - enum read_cmd_gen_state_t {IDLE, ISSUE, DRAIN, DONE}.
  - struct ReadCmdPacket {valid, cu_id_t cu_id, addr[0:63], size[0:7]}.
- One sub-module, cu_credit_counter: up/down counter with saturation and error flag, parameterised by max count. Reusable for the write path with CREDITS_WRITE.

Test Plan:
- Aligned job: base 0x1000, count 64 (256 B), cmd_ready = 1 → 2 commands {0x1000, 128}, {0x1080, 128} on consecutive cycles. After 2 credit_returns, job_done pulses once.
- Unaligned job: base 0x1078, count 40 (160 B) → commands {0x1078, 8}, {0x1080, 128}, {0x1100, 24}.
- Credit exhaustion: count 32×40 (40 lines), no credit_return → exactly 32 accepts, then cmd_valid = 0 and outstanding = 32. One return → exactly 1 more command the next cycle.
- Backpressure plus simultaneous events: hold cmd_ready = 0 for 5 cycles → cmd_addr/cmd_size stable. Accept coincident with credit_return → outstanding unchanged.
- Zero count and error: count 0 → job_done 2 cycles after handshake with no cmd_valid. A credit_return in IDLE with outstanding = 0 → credit_error = 1 and stays 1 until rst.
- Reset mid-ISSUE (after 3 accepts) → next cycle: job_ready = 1, outstanding = 0, cmd_valid = 0, no job_done.

Source files
------------

// File: rtl/cu_read_cmd_generator_pkg.sv
// Shared types and constants for the CU read command generator.
// Holds the FSM state enum, the read command packet layout and the
// helper that sizes a command so it never crosses a cacheline.
package cu_read_cmd_generator_pkg;

    localparam int CREDITS_READ   = 32;
    localparam int DATA_SIZE_READ = 4;
    localparam int CACHELINE_SIZE = 128;

    // Byte count of a job: 32-bit element count times element size, with headroom.
    localparam int REMAINING_W = 38;

    typedef logic [7:0] cu_id_t;

    localparam cu_id_t      DATA_READ_CONTROL_ID       = 8'h10;
    localparam logic [63:0] ADDRESS_DATA_READ_MOD_MASK = 64'(CACHELINE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } read_cmd_gen_state_t;

    typedef struct packed {
        logic        valid;
        cu_id_t      cu_id;
        logic [0:63] addr;
        logic [0:7]  size;
    } ReadCmdPacket;

    // Bytes that fit before the next line boundary, capped by what is left.
    function automatic logic [7:0] cmd_size_calc(
        input logic [63:0]            addr,
        input logic [REMAINING_W-1:0] remaining,
        input int unsigned            line_bytes
    );
        logic [REMAINING_W-1:0] room;
        room = REMAINING_W'(line_bytes) - REMAINING_W'(addr & 64'(line_bytes - 1));
        if (remaining < room) begin
            return remaining[7:0];
        end
        return room[7:0];
    endfunction

endpackage

// File: rtl/cu_read_cmd_generator_credit.sv
// cu_credit_counter: credit pool counter starting full at MAX_COUNT.
// inc_i returns a credit, dec_i consumes one; both together cancel.
// Overflow or underflow attempts are dropped and raise a sticky error.
module cu_credit_counter #(
    parameter int MAX_COUNT = 32,
    parameter int COUNT_W   = $clog2(MAX_COUNT + 1)
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               error_o
);

    logic [COUNT_W-1:0] count_q, count_d;
    logic               error_q, error_d;

    // Next-count logic with saturation at both ends.
    always_comb begin
        count_d = count_q;
        error_d = error_q;
        if (inc_i && !dec_i) begin
            if (count_q == COUNT_W'(MAX_COUNT)) begin
                error_d = 1'b1;
            end else begin
                count_d = count_q + COUNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                error_d = 1'b1;
            end else begin
                count_d = count_q - COUNT_W'(1);
            end
        end
    end

    // Pool starts full; the error flag is only cleared by reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count_q <= COUNT_W'(MAX_COUNT);
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign count_o = count_q;
    assign error_o = error_q;

endmodule

// File: rtl/cu_read_cmd_generator.sv
// cu_read_cmd_generator: turns one read job (byte address + element count)
// into cacheline-bounded read commands, gated by a local credit pool, and
// pulses job_done once every issued command has returned its credit.
// Optional macro CU_READ_CMD_STATS_EN adds stall_credit_cycles and
// stall_ready_cycles counters.
module cu_read_cmd_generator
    import cu_read_cmd_generator_pkg::*;
#(
    parameter int     NUM_CREDITS = CREDITS_READ,
    parameter int     ELEM_BYTES  = DATA_SIZE_READ,
    parameter int     LINE_BYTES  = CACHELINE_SIZE,
    parameter cu_id_t CU_ID       = DATA_READ_CONTROL_ID
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [0:63] job_base_addr,
    input  logic [31:0] job_elem_count,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [63:0] cmd_addr,
    output logic [7:0]  cmd_size,
    output cu_id_t      cmd_cu_id,
    input  logic        credit_return,
    output logic        job_done,
    output logic [5:0]  outstanding,
`ifdef CU_READ_CMD_STATS_EN
    output logic [31:0] stall_credit_cycles,
    output logic [31:0] stall_ready_cycles,
`endif
    output logic        credit_error
);

    localparam int CW = $clog2(NUM_CREDITS + 1);

    read_cmd_gen_state_t    state_q;
    logic [63:0]            addr_q;
    logic [REMAINING_W-1:0] remaining_q;
    logic [7:0]             size_q;
    logic                   job_ready_q;
    logic                   job_done_q;
    cu_id_t                 cu_id_q;

    logic [CW-1:0]          credits;
    logic                   credits_full;
    logic                   cmd_valid_w;
    logic                   accept;
    logic                   job_fire;
    logic [REMAINING_W-1:0] job_bytes;
    logic [7:0]             first_size;
    logic [63:0]            next_addr;
    logic [REMAINING_W-1:0] next_remaining;
    logic [7:0]             next_size;
    ReadCmdPacket           cmd_pkt;

    assign job_fire     = job_valid && job_ready_q;
    assign credits_full = (credits == CW'(NUM_CREDITS));
    assign cmd_valid_w  = (state_q == ISSUE) && (remaining_q != '0) && (credits != '0);
    assign accept       = cmd_valid_w && cmd_ready;

    // Sizing for the first command of a new job and for the command after an accept.
    // Only the first command can be unaligned; every later one starts on a line.
    assign job_bytes      = REMAINING_W'(job_elem_count) * REMAINING_W'(ELEM_BYTES);
    assign first_size     = cmd_size_calc(job_base_addr, job_bytes, LINE_BYTES);
    assign next_addr      = addr_q + 64'(size_q);
    assign next_remaining = remaining_q - REMAINING_W'(size_q);
    assign next_size      = cmd_size_calc(next_addr, next_remaining, LINE_BYTES);

    cu_credit_counter #(
        .MAX_COUNT (NUM_CREDITS),
        .COUNT_W   (CW)
    ) u_credit_counter (
        .clk_i   (clock),
        .srst_i  (rst),
        .inc_i   (credit_return),
        .dec_i   (accept),
        .count_o (credits),
        .error_o (credit_error)
    );

    // Job FSM: latch the job, issue commands, wait for all credits, pulse done.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            size_q      <= '0;
            job_ready_q <= 1'b1;
            job_done_q  <= 1'b0;
            cu_id_q     <= '0;
        end else begin
            job_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // job_ready stays low for the cycle carrying the done pulse.
                    job_ready_q <= 1'b1;
                    if (job_fire) begin
                        job_ready_q <= 1'b0;
                        addr_q      <= job_base_addr;
                        remaining_q <= job_bytes;
                        size_q      <= first_size;
                        cu_id_q     <= CU_ID;
                        state_q     <= (job_bytes == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        addr_q      <= next_addr;
                        remaining_q <= next_remaining;
                        size_q      <= next_size;
                        if (next_remaining == '0) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (credits_full) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    job_done_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_pkt = '{valid: cmd_valid_w, cu_id: cu_id_q, addr: addr_q, size: size_q};

    assign cmd_valid   = cmd_pkt.valid;
    assign cmd_addr    = cmd_pkt.addr;
    assign cmd_size    = cmd_pkt.size;
    assign cmd_cu_id   = cmd_pkt.cu_id;
    assign job_ready   = job_ready_q;
    assign job_done    = job_done_q;
    assign outstanding = 6'(NUM_CREDITS) - 6'(credits);

`ifdef CU_READ_CMD_STATS_EN
    logic [31:0] stall_credit_q;
    logic [31:0] stall_ready_q;

    // Saturating stall counters, cleared when a new job is accepted.
    always_ff @(posedge clock) begin
        if (rst || job_fire) begin
            stall_credit_q <= '0;
            stall_ready_q  <= '0;
        end else begin
            if ((state_q == ISSUE) && (remaining_q != '0) && (credits == '0)
                && (stall_credit_q != '1)) begin
                stall_credit_q <= stall_credit_q + 32'd1;
            end
            if (cmd_valid_w && !cmd_ready && (stall_ready_q != '1)) begin
                stall_ready_q <= stall_ready_q + 32'd1;
            end
        end
    end

    assign stall_credit_cycles = stall_credit_q;
    assign stall_ready_cycles  = stall_ready_q;
`endif

endmodule

// File: tb/tb_cu_read_cmd_generator.sv
// Directed testbench for cu_read_cmd_generator: aligned and unaligned jobs,
// credit exhaustion, backpressure, zero-length jobs, credit error, reset mid-job.
module tb_cu_read_cmd_generator;

    logic        clock = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [63:0] job_base_addr;
    logic [31:0] job_elem_count;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_addr;
    logic [7:0]  cmd_size;
    logic [7:0]  cmd_cu_id;
    logic        credit_return;
    logic        job_done;
    logic [5:0]  outstanding;
    logic        credit_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_cyc   = 0;

    logic [63:0] got_addr[$];
    logic [7:0]  got_size[$];
    int          got_cyc[$];

    always #5 clock = ~clock;

    cu_read_cmd_generator dut (
        .clock          (clock),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_base_addr  (job_base_addr),
        .job_elem_count (job_elem_count),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_size       (cmd_size),
        .cmd_cu_id      (cmd_cu_id),
        .credit_return  (credit_return),
        .job_done       (job_done),
        .outstanding    (outstanding),
        .credit_error   (credit_error)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Inputs only change just after a rising edge, so the falling edge sees stable values.
    always @(negedge clock) begin
        if (!rst && cmd_valid && cmd_ready) begin
            got_addr.push_back(cmd_addr);
            got_size.push_back(cmd_size);
            got_cyc.push_back(cyc);
            $display("cycle %0d: cmd accepted addr=0x%0h size=%0d cu_id=0x%0h outstanding=%0d",
                     cyc, cmd_addr, cmd_size, cmd_cu_id, outstanding);
        end
        if (!rst && job_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            $display("cycle %0d: job_done", cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_job(input logic [63:0] addr, input logic [31:0] count);
        int waited = 0;
        while (!job_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("job_ready_before_start", job_ready, 1'b1);
        job_valid      = 1'b1;
        job_base_addr  = addr;
        job_elem_count = count;
        tick();
        hs_cyc    = cyc;
        job_valid = 1'b0;
        $display("cycle %0d: job accepted base=0x%0h count=%0d", hs_cyc, addr, count);
    endtask

    task automatic wait_cmds(input int n);
        int waited = 0;
        while (got_addr.size() < n && waited < 100) begin
            tick();
            waited++;
        end
        check("cmd_count", got_addr.size(), n);
    endtask

    task automatic wait_done(input int target);
        int waited = 0;
        while (done_cnt < target && waited < 50) begin
            tick();
            waited++;
        end
        check("job_done_seen", done_cnt, target);
    endtask

    task automatic return_credits(input int n);
        credit_return = 1'b1;
        tick(n);
        credit_return = 1'b0;
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_size.delete();
        got_cyc.delete();
    endtask

    initial begin
        rst            = 1'b1;
        job_valid      = 1'b0;
        job_base_addr  = '0;
        job_elem_count = '0;
        cmd_ready      = 1'b0;
        credit_return  = 1'b0;
        tick(3);

        // Reset state
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_outstanding", outstanding, 6'd0);
        check("rst_job_done", job_done, 1'b0);
        check("rst_credit_error", credit_error, 1'b0);
        check("rst_cmd_addr", cmd_addr, 64'h0);
        check("rst_cmd_size", cmd_size, 8'd0);
        rst = 1'b0;
        tick(2);

        // Aligned job: 256 B at 0x1000 -> two full lines back to back
        cmd_ready = 1'b1;
        clear_log();
        start_job(64'h1000, 32'd64);
        wait_cmds(2);
        if (got_addr.size() == 2) begin
            check("al_addr0", got_addr[0], 64'h1000);
            check("al_size0", got_size[0], 8'd128);
            check("al_addr1", got_addr[1], 64'h1080);
            check("al_size1", got_size[1], 8'd128);
            check("al_b2b", got_cyc[1] - got_cyc[0], 1);
        end
        check("al_cu_id", cmd_cu_id, 8'h10);
        tick(3);
        check("al_outstanding", outstanding, 6'd2);
        check("al_no_early_done", done_cnt, 0);
        return_credits(2);
        wait_done(1);
        tick(3);
        check("al_single_done", done_cnt, 1);
        check("al_outstanding_end", outstanding, 6'd0);
        check("al_job_ready_end", job_ready, 1'b1);

        // Unaligned job: 160 B at 0x1078
        clear_log();
        start_job(64'h1078, 32'd40);
        wait_cmds(3);
        if (got_addr.size() == 3) begin
            check("ua_addr0", got_addr[0], 64'h1078);
            check("ua_size0", got_size[0], 8'd8);
            check("ua_addr1", got_addr[1], 64'h1080);
            check("ua_size1", got_size[1], 8'd128);
            check("ua_addr2", got_addr[2], 64'h1100);
            check("ua_size2", got_size[2], 8'd24);
        end
        return_credits(3);
        wait_done(2);

        // Credit exhaustion: 40 lines, no returns
        clear_log();
        start_job(64'h2000, 32'd1280);
        tick(40);
        check("ex_accepts", got_addr.size(), 32);
        check("ex_cmd_valid_off", cmd_valid, 1'b0);
        check("ex_outstanding", outstanding, 6'd32);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check("ex_reenable", cmd_valid, 1'b1);
        tick(4);
        check("ex_one_more", got_addr.size(), 33);
        check("ex_outstanding2", outstanding, 6'd32);
        check("ex_cmd_valid_off2", cmd_valid, 1'b0);
        if (got_addr.size() == 33) begin
            check("ex_addr32", got_addr[32], 64'h3000);
            check("ex_size32", got_size[32], 8'd128);
        end
        return_credits(39);
        wait_done(3);
        check("ex_total", got_addr.size(), 40);
        check("ex_outstanding_end", outstanding, 6'd0);
        check("ex_no_error", credit_error, 1'b0);

        // Backpressure, then an accept coinciding with a credit return
        clear_log();
        cmd_ready = 1'b0;
        start_job(64'h4010, 32'd64);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", cmd_valid, 1'b1);
            check("bp_addr", cmd_addr, 64'h4010);
            check("bp_size", cmd_size, 8'd112);
            tick();
        end
        check("bp_no_accept", got_addr.size(), 0);
        cmd_ready = 1'b1;
        tick();
        check("bp_outstanding1", outstanding, 6'd1);
        check("bp_addr_next", cmd_addr, 64'h4080);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check("bp_simul_outstanding", outstanding, 6'd1);
        check("bp_addr_last", cmd_addr, 64'h4100);
        check("bp_size_last", cmd_size, 8'd16);
        tick();
        cmd_ready = 1'b0;
        check("bp_outstanding2", outstanding, 6'd2);
        check("bp_total", got_addr.size(), 3);
        return_credits(2);
        wait_done(4);

        // Zero-length job: done two cycles after the handshake, no commands
        clear_log();
        cmd_ready = 1'b1;
        start_job(64'h5000, 32'd0);
        check("z_valid_t1", cmd_valid, 1'b0);
        check("z_ready_t1", job_ready, 1'b0);
        check("z_done_t1", job_done, 1'b0);
        tick();
        check("z_done_t2", job_done, 1'b1);
        check("z_ready_t2", job_ready, 1'b0);
        tick();
        check("z_done_t3", job_done, 1'b0);
        check("z_ready_t3", job_ready, 1'b1);
        check("z_done_cycle", done_cyc, hs_cyc + 1);
        check("z_no_cmds", got_addr.size(), 0);
        check("z_done_count", done_cnt, 5);

        // Spurious credit return in IDLE sets a sticky error
        check("err_pre", credit_error, 1'b0);
        return_credits(1);
        check("err_set", credit_error, 1'b1);
        check("err_outstanding", outstanding, 6'd0);
        tick(5);
        check("err_sticky", credit_error, 1'b1);

        // Reset in the middle of ISSUE after three accepts
        clear_log();
        start_job(64'h6000, 32'd320);
        tick(3);
        rst       = 1'b1;
        cmd_ready = 1'b0;
        tick();
        check("mr_job_ready", job_ready, 1'b1);
        check("mr_outstanding", outstanding, 6'd0);
        check("mr_cmd_valid", cmd_valid, 1'b0);
        check("mr_job_done", job_done, 1'b0);
        check("mr_error_clear", credit_error, 1'b0);
        rst = 1'b0;
        tick(6);
        check("mr_accepts", got_addr.size(), 3);
        check("mr_no_done", done_cnt, 5);
        check("mr_idle_valid", cmd_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
